// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG coefficient packer/unpacker pair: FSM states,
// run-length symbol constants and the zig-zag to natural-order index map.
package jpeg_pkg;

   localparam int COEF_W_DEF = 12;

   typedef enum logic [1:0] {
      S_DC,
      S_AC,
      S_DRAIN
   } state_t;

   localparam logic [3:0] RUN_EOB   = 4'd0;
   localparam logic [3:0] RUN_ZRL   = 4'd15;
   localparam logic [3:0] SIZE_NONE = 4'd0;
   localparam logic [3:0] DC_SIZE_MAX = 4'd11;
   localparam logic [3:0] AC_SIZE_MAX = 4'd10;

   function automatic logic [5:0] zz2nat(input logic [5:0] zz);
      logic [5:0] nat;
      case (zz)
         6'd0:  nat = 6'd0;   6'd1:  nat = 6'd1;   6'd2:  nat = 6'd8;   6'd3:  nat = 6'd16;
         6'd4:  nat = 6'd9;   6'd5:  nat = 6'd2;   6'd6:  nat = 6'd3;   6'd7:  nat = 6'd10;
         6'd8:  nat = 6'd17;  6'd9:  nat = 6'd24;  6'd10: nat = 6'd32;  6'd11: nat = 6'd25;
         6'd12: nat = 6'd18;  6'd13: nat = 6'd11;  6'd14: nat = 6'd4;   6'd15: nat = 6'd5;
         6'd16: nat = 6'd12;  6'd17: nat = 6'd19;  6'd18: nat = 6'd26;  6'd19: nat = 6'd33;
         6'd20: nat = 6'd40;  6'd21: nat = 6'd48;  6'd22: nat = 6'd41;  6'd23: nat = 6'd34;
         6'd24: nat = 6'd27;  6'd25: nat = 6'd20;  6'd26: nat = 6'd13;  6'd27: nat = 6'd6;
         6'd28: nat = 6'd7;   6'd29: nat = 6'd14;  6'd30: nat = 6'd21;  6'd31: nat = 6'd28;
         6'd32: nat = 6'd35;  6'd33: nat = 6'd42;  6'd34: nat = 6'd49;  6'd35: nat = 6'd56;
         6'd36: nat = 6'd57;  6'd37: nat = 6'd50;  6'd38: nat = 6'd43;  6'd39: nat = 6'd36;
         6'd40: nat = 6'd29;  6'd41: nat = 6'd22;  6'd42: nat = 6'd15;  6'd43: nat = 6'd23;
         6'd44: nat = 6'd30;  6'd45: nat = 6'd37;  6'd46: nat = 6'd44;  6'd47: nat = 6'd51;
         6'd48: nat = 6'd58;  6'd49: nat = 6'd59;  6'd50: nat = 6'd52;  6'd51: nat = 6'd45;
         6'd52: nat = 6'd38;  6'd53: nat = 6'd31;  6'd54: nat = 6'd39;  6'd55: nat = 6'd46;
         6'd56: nat = 6'd53;  6'd57: nat = 6'd60;  6'd58: nat = 6'd61;  6'd59: nat = 6'd54;
         6'd60: nat = 6'd47;  6'd61: nat = 6'd55;  6'd62: nat = 6'd62;  default: nat = 6'd63;
      endcase
      return nat;
   endfunction

endpackage

// File: rtl/jpeg_zigzag_lut.sv
// Combinational zig-zag position to natural (raster) index map.
module jpeg_zigzag_lut
   import jpeg_pkg::*;
(
   input  logic [5:0] zz,
   output logic [5:0] nat
);

   assign nat = zz2nat(zz);

endmodule

// File: rtl/jpeg_coef_unpack.sv
// Rebuilds one 8x8 block from (run, size, amplitude) symbols and streams the
// 64 coefficients in natural order.
module jpeg_coef_unpack
   import jpeg_pkg::*;
#(
   parameter int COEF_W = COEF_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_run,
   input  logic [3:0]               in_size,
   input  logic [10:0]              in_amp,
   input  logic                     restart,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [COEF_W-1:0] out_coef,
   output logic [5:0]               out_idx,
   output logic                     out_last,
   output logic                     err
);

   // Size 0 and out-of-range sizes both extend to zero; range errors are flagged separately.
   function automatic logic signed [COEF_W-1:0] amp_ext(input logic [3:0] size,
                                                        input logic [10:0] amp);
      logic [11:0]        lim;
      logic [11:0]        field;
      logic signed [12:0] v;
      lim   = (12'd1 << size) - 12'd1;
      field = {1'b0, amp} & lim;
      if (size == SIZE_NONE || size > DC_SIZE_MAX)
         v = '0;
      else if (field[size - 4'd1])
         v = signed'({1'b0, field});
      else
         v = signed'({1'b0, field}) - signed'({1'b0, lim});
      return COEF_W'(v);
   endfunction

   state_t                   state, state_nx;
   logic [5:0]               k, k_nx;
   logic [5:0]               d;
   logic signed [COEF_W-1:0] pred;
   logic [63:0]              wmask;
   logic signed [COEF_W-1:0] coef_buf [64];

   logic                     accept, dc_acc, drain_hs, drain_done;
   logic                     wr_en, err_set;
   logic [5:0]               wr_idx, nat_idx;
   logic signed [COEF_W-1:0] wr_val, v_ext, pred_eff, dc_coef;
   logic [6:0]               p_sum, zrl_sum;

   assign in_ready   = (state != S_DRAIN);
   assign out_valid  = (state == S_DRAIN);
   assign out_idx    = d;
   assign out_last   = out_valid && (d == 6'd63);
   assign out_coef   = wmask[d] ? coef_buf[d] : '0;

   assign accept     = in_valid && in_ready;
   assign dc_acc     = accept && (state == S_DC);
   assign drain_hs   = out_valid && out_ready;
   assign drain_done = drain_hs && (d == 6'd63);

   assign v_ext    = amp_ext(in_size, in_amp);
   assign pred_eff = restart ? '0 : pred;
   assign dc_coef  = pred_eff + v_ext;
   assign p_sum    = {1'b0, k} + {3'b000, in_run};
   assign zrl_sum  = {1'b0, k} + 7'd16;

   jpeg_zigzag_lut u_zigzag (
      .zz  (p_sum[5:0]),
      .nat (nat_idx)
   );

   always_comb begin
      state_nx = state;
      k_nx     = k;
      wr_en    = 1'b0;
      wr_idx   = nat_idx;
      wr_val   = v_ext;
      err_set  = 1'b0;
      case (state)
         S_DC: begin
            if (accept) begin
               wr_en    = 1'b1;
               wr_idx   = 6'd0;
               wr_val   = dc_coef;
               k_nx     = 6'd1;
               state_nx = S_AC;
               err_set  = (in_size > DC_SIZE_MAX);
            end
         end
         S_AC: begin
            if (accept) begin
               if (in_size == SIZE_NONE && in_run == RUN_EOB) begin
                  state_nx = S_DRAIN;
               end else if (in_size == SIZE_NONE && in_run == RUN_ZRL) begin
                  k_nx = zrl_sum[5:0];
                  if (zrl_sum > 7'd63) begin
                     err_set  = 1'b1;
                     state_nx = S_DRAIN;
                  end
               end else if (in_size == SIZE_NONE) begin
                  err_set  = 1'b1;
                  state_nx = S_DRAIN;
               end else if (p_sum > 7'd63 || in_size > AC_SIZE_MAX) begin
                  err_set  = 1'b1;
                  state_nx = S_DRAIN;
               end else begin
                  wr_en = 1'b1;
                  k_nx  = p_sum[5:0] + 6'd1;
                  if (p_sum == 7'd63)
                     state_nx = S_DRAIN;
               end
            end
         end
         default: begin
            if (drain_done)
               state_nx = S_DC;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_DC;
         k     <= '0;
         d     <= '0;
         pred  <= '0;
         err   <= 1'b0;
         wmask <= '0;
      end else begin
         state <= state_nx;
         k     <= k_nx;
         if (err_set)
            err <= 1'b1;
         if (dc_acc)
            pred <= dc_coef;
         else if (restart)
            pred <= '0;
         if (drain_hs)
            d <= d + 6'd1;
         // The mask, not the buffer, defines block contents, so a one-cycle clear suffices.
         if (drain_done)
            wmask <= '0;
         else if (wr_en)
            wmask[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         coef_buf[wr_idx] <= wr_val;
   end

endmodule

// File: tb/tb_jpeg_coef_unpack.sv
// Scoreboard bench for jpeg_coef_unpack: a block-level reference model queues
// the expected 64-coefficient stream; a monitor checks whatever the DUT emits.
module tb_jpeg_coef_unpack;

   localparam int COEF_W = 12;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_run;
   logic [3:0]        in_size;
   logic [10:0]       in_amp;
   logic              restart;
   logic              out_valid;
   logic              out_ready;
   logic signed [COEF_W-1:0] out_coef;
   logic [5:0]        out_idx;
   logic              out_last;
   logic              err;

   jpeg_coef_unpack #(.COEF_W(COEF_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_run    (in_run),
      .in_size   (in_size),
      .in_amp    (in_amp),
      .restart   (restart),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_coef  (out_coef),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int idx;
      int coef;
      int last;
   } exp_t;

   int   n_cmp  = 0;
   int   n_miss = 0;
   int   zz_nat [64];
   int   blk    [64];
   int   m_pred, m_k, m_err;
   bit   m_have_dc;
   exp_t q [$];
   int   rdy_mode = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int ext(input int size, input int amp);
      int f;
      if (size == 0) return 0;
      f = amp & ((1 << size) - 1);
      if (((f >> (size - 1)) & 1) == 1) return f;
      return f - ((1 << size) - 1);
   endfunction

   function automatic int wrap(input int x);
      int y;
      y = x & 4095;
      return (y >= 2048) ? y - 4096 : y;
   endfunction

   task automatic model_reset;
      m_pred = 0; m_k = 0; m_err = 0; m_have_dc = 1'b0;
      for (int i = 0; i < 64; i++) blk[i] = 0;
      q.delete();
   endtask

   task automatic close_block;
      exp_t e;
      for (int i = 0; i < 64; i++) begin
         e.idx = i; e.coef = blk[i]; e.last = (i == 63) ? 1 : 0;
         q.push_back(e);
         blk[i] = 0;
      end
      m_have_dc = 1'b0;
   endtask

   task automatic model_sym(input int run, input int size, input int amp, input bit rs);
      int p;
      bit close;
      if (rs) m_pred = 0;
      if (!m_have_dc) begin
         blk[0] = wrap(m_pred + ((size > 11) ? 0 : ext(size, amp)));
         m_pred = blk[0];
         if (size > 11) m_err = 1;
         m_k = 1;
         m_have_dc = 1'b1;
      end else begin
         close = 1'b0;
         if (size == 0 && run == 0) close = 1'b1;
         else if (size == 0 && run == 15) begin
            m_k += 16;
            if (m_k > 63) begin m_err = 1; close = 1'b1; end
         end else if (size == 0) begin
            m_err = 1; close = 1'b1;
         end else begin
            p = m_k + run;
            if (p > 63 || size > 10) begin
               m_err = 1; close = 1'b1;
            end else begin
               blk[zz_nat[p]] = ext(size, amp);
               m_k = p + 1;
               if (p == 63) close = 1'b1;
            end
         end
         if (close) close_block();
      end
   endtask

   task automatic send(input int run, input int size, input int amp, input bit rs);
      int guard = 0;
      while (!in_ready && guard < 1000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 0, 1);
      end else begin
         in_valid = 1'b1;
         in_run   = run[3:0];
         in_size  = size[3:0];
         in_amp   = amp[10:0];
         restart  = rs;
         model_sym(run, size, amp, rs);
         @(posedge clk); #1;
         in_valid = 1'b0;
         restart  = 1'b0;
      end
   endtask

   task automatic rand_block;
      int sz, c, guard;
      sz = ($urandom_range(0, 19) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11);
      send($urandom_range(0, 15), sz, $urandom_range(0, 2047), $urandom_range(0, 7) == 0);
      guard = 0;
      while (m_have_dc && guard < 80) begin
         c = $urandom_range(0, 99);
         if (c < 8)       send(0, 0, 0, 1'b0);
         else if (c < 13) send(15, 0, 0, 1'b0);
         else if (c < 15) send($urandom_range(1, 14), 0, 0, 1'b0);
         else if (c < 17) send($urandom_range(0, 15), 11, $urandom_range(0, 2047), 1'b0);
         else send(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2),
                   $urandom_range(1, 10), $urandom_range(0, 2047), $urandom_range(0, 15) == 0);
         guard++;
      end
   endtask

   // Reference zig-zag order built by walking the anti-diagonals.
   initial begin
      int n;
      n = 0;
      for (int s = 0; s < 15; s++) begin
         if (s % 2 == 0) begin
            for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
               zz_nat[n] = r * 8 + (s - r); n++;
            end
         end else begin
            for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
               zz_nat[n] = r * 8 + (s - r); n++;
            end
         end
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_output_idx", int'(out_idx), -1);
            end else begin
               e = q[0];
               chk("out_idx", int'(out_idx), e.idx);
               chk("out_coef", int'(out_coef), e.coef);
               chk("out_last", int'(out_last), e.last);
               if (out_ready) begin
                  chk("err", int'(err), m_err);
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      int guard;
      rst = 1'b1; in_valid = 1'b0; in_run = '0; in_size = '0; in_amp = '0; restart = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_idx", int'(out_idx), 0);
      chk("rst_out_coef", int'(out_coef), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_err", int'(err), 0);

      // DC only
      send(0, 3, 5, 1'b0);  send(0, 0, 0, 1'b0);
      // Negative amplitudes with prediction, then restart
      send(0, 2, 1, 1'b1);  send(0, 0, 0, 1'b0);
      send(0, 1, 0, 1'b0);  send(0, 0, 0, 1'b0);
      send(0, 1, 0, 1'b1);  send(0, 0, 0, 1'b0);
      // AC placement
      send(0, 0, 0, 1'b1);  send(0, 1, 1, 1'b0);  send(2, 2, 2, 1'b0);  send(0, 0, 0, 1'b0);
      // Full block closes itself at position 63
      send(0, 0, 0, 1'b0);
      for (int i = 0; i < 63; i++) send(0, 1, 1, 1'b0);
      // Overflow through ZRLs, then a good block with err still set
      send(0, 1, 1, 1'b0);
      for (int i = 0; i < 3; i++) send(15, 0, 0, 1'b0);
      send(15, 1, 1, 1'b0);
      send(0, 2, 3, 1'b0);  send(0, 0, 0, 1'b0);
      // Alternating backpressure
      rdy_mode = 1;
      send(0, 4, 9, 1'b0);  send(1, 3, 2, 1'b0);  send(0, 0, 0, 1'b0);
      // Reset in the middle of a drain
      send(0, 0, 0, 1'b0);
      rdy_mode = 0;
      send(0, 5, 20, 1'b1); send(0, 1, 1, 1'b0); send(0, 0, 0, 1'b0);
      guard = 0;
      #1;
      while (!(out_valid && out_idx == 6'd20) && guard < 300) begin
         @(posedge clk); #2;
         guard++;
      end
      chk("reach_drain_idx20", int'(out_valid && out_idx == 6'd20), 1);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_err", int'(err), 0);
      chk("midrst_out_idx", int'(out_idx), 0);
      model_reset();
      rst = 1'b0;
      @(posedge clk); #1;

      // Randomised blocks
      for (int b = 0; b < 30; b++) begin
         rdy_mode = $urandom_range(0, 2);
         rand_block();
      end

      guard = 0;
      while (q.size() != 0 && guard < 5000) begin
         @(posedge clk);
         guard++;
      end
      chk("drain_complete", q.size(), 0);
      @(posedge clk); #1;
      chk("final_in_ready", int'(in_ready), 1);
      chk("final_err", int'(err), m_err);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
      $finish;
   end

endmodule
